branch_operand_scoreboard: RTL and testbench

- Parametrised successor to the ID-stage branch forwarding unit.
- Tracks every in-flight register write in the post-ID stages in an internal shift scoreboard.
- For each source operand of the instruction in ID, produces a forwarding select. Also produces the ID stall, based on producer type and stage readiness, replacing the fixed 1-stall/2-stall rule in the control unit.
- Sits between the ID-stage comparator operand muxes and the hazard/stall logic. Also keeps a saturating stall-cycle counter.

---
 rtl/branch_operand_scoreboard.sv | 126 ++++++++++++
 tb/tb_branch_operand_scoreboard.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_operand_scoreboard.sv
// Branch operand scoreboard: tracks in-flight register writes behind ID and
// produces per-source forwarding selects, the ID stall and a stall counter.
module branch_operand_scoreboard #(
  parameter int AW          = 5,
  parameter int NUM_SRC     = 2,
  parameter int DEPTH       = 3,
  parameter int ALU_READY   = 2,
  parameter int LOAD_READY  = 3,
  parameter int BRANCH_ONLY = 1,
  parameter int CNT_W       = 16,
  parameter int SEL_W       = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic                     id_is_branch,
  input  logic [NUM_SRC*AW-1:0]    id_src_addr,
  input  logic [NUM_SRC-1:0]       id_src_used,
  input  logic [AW-1:0]            id_dst_addr,
  input  logic                     id_dst_we,
  input  logic                     id_is_load,
  input  logic                     flush,
  input  logic                     pipe_hold,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic                     stall,
  output logic [CNT_W-1:0]         stall_cnt
);

  // Index k-1 of each vector holds slot k (slot 1 = ID/EX, youngest).
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0]         we_q, we_d;
  logic [DEPTH-1:0]         ld_q, ld_d;
  logic [DEPTH-1:0][AW-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic                     chk_en_s;
  logic                     ins_s;
  logic [NUM_SRC-1:0]       src_stall_s;
  logic                     hit_s;
  logic                     hit_ld_s;
  int                       hit_k_s;

  assign chk_en_s  = id_valid && (id_is_branch || (BRANCH_ONLY == 0));
  assign ins_s     = id_valid && !stall && !flush;
  assign stall_cnt = cnt_q;

  // Youngest-match lookup per source; an unready youngest match stalls.
  always_comb begin
    fwd_sel     = {(NUM_SRC*SEL_W){1'b0}};
    src_stall_s = {NUM_SRC{1'b0}};
    hit_s       = 1'b0;
    hit_ld_s    = 1'b0;
    hit_k_s     = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hit_s    = 1'b0;
      hit_ld_s = 1'b0;
      hit_k_s  = 0;
      for (int k = 0; k < DEPTH; k++) begin
        if (!hit_s && valid_q[k] && we_q[k] && (dst_q[k] != {AW{1'b0}}) &&
            (dst_q[k] == id_src_addr[i*AW +: AW]) && id_src_used[i]) begin
          hit_s    = 1'b1;
          hit_ld_s = ld_q[k];
          hit_k_s  = k + 1;
        end else begin
          hit_s    = hit_s;
        end
      end
      if (chk_en_s && hit_s) begin
        if (hit_k_s >= (hit_ld_s ? LOAD_READY : ALU_READY)) begin
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(hit_k_s);
        end else begin
          src_stall_s[i] = 1'b1;
        end
      end else begin
        fwd_sel[i*SEL_W +: SEL_W] = {SEL_W{1'b0}};
      end
    end
    stall = |src_stall_s;
  end

  // Shift the scoreboard and count stall cycles unless the pipe is frozen.
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    ld_d    = ld_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    if (!pipe_hold) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        valid_d[k] = valid_q[k-1];
        we_d[k]    = we_q[k-1];
        ld_d[k]    = ld_q[k-1];
        dst_d[k]   = dst_q[k-1];
      end
      valid_d[0] = ins_s;
      we_d[0]    = id_dst_we && ins_s;
      ld_d[0]    = id_is_load && ins_s;
      dst_d[0]   = id_dst_addr;
      if (stall && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= {DEPTH{1'b0}};
      we_q    <= {DEPTH{1'b0}};
      ld_q    <= {DEPTH{1'b0}};
      dst_q   <= {(DEPTH*AW){1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      ld_q    <= ld_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_operand_scoreboard.sv
// Testbench for branch_operand_scoreboard: directed pipeline scenarios plus a
// randomized stream, checked against a queue-of-producers reference model.
module tb_branch_operand_scoreboard;

  localparam int AW          = 5;
  localparam int NUM_SRC     = 2;
  localparam int DEPTH       = 3;
  localparam int ALU_READY   = 2;
  localparam int LOAD_READY  = 3;
  localparam int BRANCH_ONLY = 1;
  localparam int SEL_W       = 2;

  logic                     clk = 1'b0;
  logic                     reset, id_valid, id_is_branch, id_dst_we, id_is_load;
  logic                     flush, pipe_hold;
  logic [NUM_SRC*AW-1:0]    id_src_addr;
  logic [NUM_SRC-1:0]       id_src_used;
  logic [AW-1:0]            id_dst_addr;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel, fwd_sel2;
  logic                     stall, stall2;
  logic [15:0]              stall_cnt;
  logic [1:0]               stall_cnt2;
  logic [SEL_W-1:0]         sel0, sel1;

  assign sel0 = fwd_sel[0 +: SEL_W];
  assign sel1 = fwd_sel[SEL_W +: SEL_W];

  branch_operand_scoreboard dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_is_branch(id_is_branch),
    .id_src_addr(id_src_addr), .id_src_used(id_src_used), .id_dst_addr(id_dst_addr),
    .id_dst_we(id_dst_we), .id_is_load(id_is_load), .flush(flush), .pipe_hold(pipe_hold),
    .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
  );

  branch_operand_scoreboard #(.CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_is_branch(id_is_branch),
    .id_src_addr(id_src_addr), .id_src_used(id_src_used), .id_dst_addr(id_dst_addr),
    .id_dst_we(id_dst_we), .id_is_load(id_is_load), .flush(flush), .pipe_hold(pipe_hold),
    .fwd_sel(fwd_sel2), .stall(stall2), .stall_cnt(stall_cnt2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: in-flight producers with their age in stages past ID.
  typedef struct {
    logic [AW-1:0] dst;
    logic          we;
    logic          ld;
    int            age;
  } prod_t;
  prod_t m_q[$];
  int    m_cnt  = 0;
  int    m_cnt2 = 0;

  function automatic void model_eval(output logic [NUM_SRC*SEL_W-1:0] sel, output logic st);
    int   best_age;
    logic best_ld;
    sel = '0;
    st  = 1'b0;
    if (id_valid && (id_is_branch || BRANCH_ONLY == 0)) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        best_age = DEPTH + 1;
        best_ld  = 1'b0;
        foreach (m_q[j]) begin
          if (m_q[j].we && m_q[j].dst != 0 && id_src_used[i] &&
              m_q[j].dst == id_src_addr[i*AW +: AW] && m_q[j].age < best_age) begin
            best_age = m_q[j].age;
            best_ld  = m_q[j].ld;
          end
        end
        if (best_age <= DEPTH) begin
          if (best_age >= (best_ld ? LOAD_READY : ALU_READY))
            sel[i*SEL_W +: SEL_W] = best_age[SEL_W-1:0];
          else
            st = 1'b1;
        end
      end
    end
  endfunction

  task automatic tick();
    logic [NUM_SRC*SEL_W-1:0] s;
    logic                     st;
    prod_t                    nq[$];
    prod_t                    p;
    model_eval(s, st);
    @(posedge clk);
    if (reset) begin
      m_q.delete();
      m_cnt  = 0;
      m_cnt2 = 0;
    end else if (!pipe_hold) begin
      if (st) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      foreach (m_q[j]) begin
        if (m_q[j].age < DEPTH) begin
          p = m_q[j];
          p.age++;
          nq.push_back(p);
        end
      end
      if (id_valid && !st && !flush) begin
        p.dst = id_dst_addr;
        p.we  = id_dst_we;
        p.ld  = id_is_load;
        p.age = 1;
        nq.push_back(p);
      end
      m_q = nq;
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic br, input logic [AW-1:0] s0,
                       input logic [AW-1:0] s1, input logic [1:0] used,
                       input logic [AW-1:0] d, input logic we, input logic ld);
    id_valid     = v;
    id_is_branch = br;
    id_src_addr  = {s1, s0};
    id_src_used  = used;
    id_dst_addr  = d;
    id_dst_we    = we;
    id_is_load   = ld;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    drive(1'b1, 1'b1, 5'd1, 5'd2, 2'b11, 5'd0, 1'b0, 1'b0);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %0b want 0", stall); end
    n_checks++; if (fwd_sel !== '0) begin n_errors++; $display("FAIL reset_sel: got %0h want 0", fwd_sel); end
    n_checks++; if (stall_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    tick();
  endtask

  task automatic test_alu_fwd();
    pulse_reset();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b1, 5'd1, 5'd2, 2'b11, 5'd0, 1'b0, 1'b0);
    #1;
    n_checks++; if (stall !== 1'b1 || sel0 !== 2'd0) begin n_errors++; $display("FAIL alu_cycleA: stall=%0b sel0=%0d want 1/0", stall, sel0); end
    tick();
    n_checks++; if (stall !== 1'b0 || sel0 !== 2'd2 || sel1 !== 2'd0) begin n_errors++; $display("FAIL alu_fwd: stall=%0b sel0=%0d sel1=%0d want 0/2/0", stall, sel0, sel1); end
    n_checks++; if (stall_cnt !== 16'd1) begin n_errors++; $display("FAIL alu_cnt: got %0d want 1", stall_cnt); end
    tick();
  endtask

  task automatic test_load();
    pulse_reset();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b1);
    tick();
    drive(1'b1, 1'b1, 5'd3, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL load_stall%0d: got %0b want 1", c, stall); end
      tick();
    end
    n_checks++; if (stall !== 1'b0 || sel0 !== 2'd3 || sel1 !== 2'd0) begin n_errors++; $display("FAIL load_fwd: stall=%0b sel0=%0d sel1=%0d want 0/3/0", stall, sel0, sel1); end
    n_checks++; if (stall_cnt !== 16'd2) begin n_errors++; $display("FAIL load_cnt: got %0d want 2", stall_cnt); end
    tick();
  endtask

  task automatic test_two_slots();
    pulse_reset();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 5'd4, 5'd5, 2'b11, 5'd0, 1'b0, 1'b0);
    #1;
    n_checks++; if (stall !== 1'b0 || sel0 !== 2'd2 || sel1 !== 2'd3) begin n_errors++; $display("FAIL two_slots: stall=%0b sel0=%0d sel1=%0d want 0/2/3", stall, sel0, sel1); end
    tick();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 5'd4, 5'd4, 2'b11, 5'd0, 1'b0, 1'b0);
    #1;
    n_checks++; if (stall !== 1'b0 || sel0 !== 2'd2 || sel1 !== 2'd2) begin n_errors++; $display("FAIL youngest: stall=%0b sel0=%0d sel1=%0d want 0/2/2", stall, sel0, sel1); end
    tick();
    // Older ready copy in slot 3 must not be used while slot 1 holds r4.
    drive(1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b1, 5'd4, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
    #1;
    n_checks++; if (stall !== 1'b1 || sel0 !== 2'd0) begin n_errors++; $display("FAIL older_ready: stall=%0b sel0=%0d want 1/0", stall, sel0); end
    tick();
  endtask

  task automatic test_r0_and_nonbranch();
    pulse_reset();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0);
    #1;
    n_checks++; if (stall !== 1'b0 || fwd_sel !== '0) begin n_errors++; $display("FAIL r0: stall=%0b sel=%0h want 0/0", stall, fwd_sel); end
    tick();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd1, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b0, 5'd1, 5'd1, 2'b11, 5'd1, 1'b1, 1'b0);
    #1;
    n_checks++; if (stall !== 1'b0 || fwd_sel !== '0) begin n_errors++; $display("FAIL nonbranch: stall=%0b sel=%0h want 0/0", stall, fwd_sel); end
    tick();
  endtask

  task automatic test_hold_flush();
    pulse_reset();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b1); tick();
    drive(1'b1, 1'b1, 5'd6, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
    pipe_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (stall !== 1'b1 || stall_cnt !== 16'd0) begin n_errors++; $display("FAIL hold%0d: stall=%0b cnt=%0d want 1/0", c, stall, stall_cnt); end
      tick();
    end
    pipe_hold = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++; if (stall !== 1'b1 || stall_cnt !== 16'(c)) begin n_errors++; $display("FAIL release%0d: stall=%0b cnt=%0d want 1/%0d", c, stall, stall_cnt, c); end
      tick();
    end
    n_checks++; if (stall !== 1'b0 || sel0 !== 2'd3 || stall_cnt !== 16'd2) begin n_errors++; $display("FAIL release_fwd: stall=%0b sel0=%0d cnt=%0d want 0/3/2", stall, sel0, stall_cnt); end
    tick();
    // Stalled and flushed instruction writing r9 must not enter slot 1.
    drive(1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1); tick();
    drive(1'b1, 1'b1, 5'd7, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL flush_stall: got %0b want 1", stall); end
    tick();
    flush = 1'b0;
    drive(1'b1, 1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
    #1;
    n_checks++; if (stall !== 1'b0 || sel0 !== 2'd0) begin n_errors++; $display("FAIL flush_bubble: stall=%0b sel0=%0d want 0/0", stall, sel0); end
    tick();
    // Flush alone also squashes.
    drive(1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd10, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b1, 1'b1, 5'd10, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
    #1;
    n_checks++; if (stall !== 1'b0 || sel0 !== 2'd0) begin n_errors++; $display("FAIL flush_only: stall=%0b sel0=%0d want 0/0", stall, sel0); end
    tick();
  endtask

  task automatic test_saturate_and_reset();
    pulse_reset();
    for (int r = 0; r < 3; r++) begin
      drive(1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd8, 1'b1, 1'b1); tick();
      drive(1'b1, 1'b1, 5'd8, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0); tick(); tick(); tick();
      n_checks++; if (stall_cnt2 !== ((r == 0) ? 2'd2 : 2'd3)) begin n_errors++; $display("FAIL sat_round%0d: cnt2=%0d want %0d", r, stall_cnt2, (r == 0) ? 2 : 3); end
    end
    n_checks++; if (stall_cnt !== 16'd6) begin n_errors++; $display("FAIL sat_wide: cnt=%0d want 6", stall_cnt); end
    drive(1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd8, 1'b1, 1'b1); tick();
    drive(1'b1, 1'b1, 5'd8, 5'd8, 2'b11, 5'd0, 1'b0, 1'b0);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL pre_reset_stall: got %0b want 1", stall); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (stall !== 1'b0 || fwd_sel !== '0 || stall_cnt !== 16'd0 || stall_cnt2 !== 2'd0) begin
      n_errors++; $display("FAIL mid_reset: stall=%0b sel=%0h cnt=%0d cnt2=%0d want all 0", stall, fwd_sel, stall_cnt, stall_cnt2);
    end
    tick();
  endtask

  task automatic test_random();
    logic [NUM_SRC*SEL_W-1:0] es;
    logic                     est;
    pulse_reset();
    for (int c = 0; c < 600; c++) begin
      reset     = ($urandom_range(0, 49) == 0);
      pipe_hold = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      drive(($urandom_range(0, 5) != 0), ($urandom_range(0, 2) != 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
      #1;
      model_eval(es, est);
      n_checks++; if (fwd_sel !== es || stall !== est) begin n_errors++; $display("FAIL rand_out c%0d: sel=%0h stall=%0b want %0h/%0b", c, fwd_sel, stall, es, est); end
      n_checks++; if (fwd_sel2 !== es || stall2 !== est) begin n_errors++; $display("FAIL rand_out2 c%0d: sel=%0h stall=%0b want %0h/%0b", c, fwd_sel2, stall2, es, est); end
      n_checks++; if (stall_cnt !== 16'(m_cnt) || stall_cnt2 !== 2'(m_cnt2)) begin n_errors++; $display("FAIL rand_cnt c%0d: cnt=%0d cnt2=%0d want %0d/%0d", c, stall_cnt, stall_cnt2, m_cnt, m_cnt2); end
      tick();
    end
    reset     = 1'b0;
    pipe_hold = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    pipe_hold = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    #2;
    test_reset();
    test_alu_fwd();
    test_load();
    test_two_slots();
    test_r0_and_nonbranch();
    test_hold_flush();
    test_saturate_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
